// File: rtl/relm_spi_master.sv
// relm_spi_master: byte-wide SPI mode-3 master behind a push/pop slot pair.
// Push word carries SS control and TX byte; pop word returns rx, fresh, int.
module relm_spi_master #(
    parameter int WD  = 32,
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n_in,
    input  logic [WD:0] cmd_in,
    output logic        retry_out,
    input  logic        ack_in,
    output logic [WD:0] q_out,
    output logic        spi_ss_out,
    output logic        spi_sck_out,
    output logic        spi_mosi_out,
    input  logic        spi_miso_in,
    input  logic        spi_int_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic       fresh_q, fresh_d;
    logic       busy_q, busy_d;
    logic       ss_q, ss_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       miso_q;
    logic       int_meta_q;
    logic       int_sync_q;

    logic       cmd_vld;
    logic       div_last;
    logic       unused_cmd_bits;

    assign cmd_vld         = cmd_in[WD];
    assign div_last        = (div_cnt_q == DIV_LAST);
    assign unused_cmd_bits = ^cmd_in[WD-1:10];

    // Next-state logic for the command decoder and the SCK/shift sequencer.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        busy_d    = busy_q;
        ss_d      = ss_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        fresh_d   = ack_in ? 1'b0 : fresh_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    ss_d = cmd_in[8];
                    if (!cmd_in[9]) begin
                        mosi_d    = cmd_in[7];
                        shift_d   = cmd_in[7:0];
                        bit_cnt_d = 3'd7;
                        busy_d    = 1'b1;
                        sck_d     = 1'b0;
                        div_cnt_d = 8'd0;
                        state_d   = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (div_last) begin
                    div_cnt_d = 8'd0;
                    sck_d     = 1'b1;
                    state_d   = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_HIGH: begin
                // Registered MISO is sampled once, right after the rise.
                if (div_cnt_q == 8'd0) begin
                    shift_d = {shift_q[6:0], miso_q};
                end
                if (div_last) begin
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd0) begin
                        rx_d    = shift_q;
                        fresh_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        mosi_d    = shift_q[7];
                        sck_d     = 1'b0;
                        state_d   = S_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer, SPI pin and pop-word registers.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            rx_q      <= 8'd0;
            fresh_q   <= 1'b0;
            busy_q    <= 1'b0;
            ss_q      <= 1'b1;
            sck_q     <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            fresh_q   <= fresh_d;
            busy_q    <= busy_d;
            ss_q      <= ss_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
        end
    end

    // Input capture: MISO register and two-flop interrupt synchronizer.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            miso_q     <= 1'b0;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            miso_q     <= spi_miso_in;
            int_meta_q <= spi_int_in;
            int_sync_q <= int_meta_q;
        end
    end

    assign retry_out    = busy_q;
    assign spi_ss_out   = ss_q;
    assign spi_sck_out  = sck_q;
    assign spi_mosi_out = mosi_q;
    assign q_out        = {1'b0, fresh_q, int_sync_q, {(WD-10){1'b0}}, rx_q};

endmodule

// File: tb/tb_relm_spi_master.sv
// tb_relm_spi_master: directed bench for the SPI master.
// Loopback and a shifting slave model drive MISO.
module tb_relm_spi_master;

    localparam int WD  = 32;
    localparam int DIV = 4;

    logic        clk;
    logic        rst_n_in;
    logic [WD:0] cmd_in;
    logic        retry_out;
    logic        ack_in;
    logic [WD:0] q_out;
    logic        spi_ss_out;
    logic        spi_sck_out;
    logic        spi_mosi_out;
    logic        spi_miso_in;
    logic        spi_int_in;

    int vectors = 0;
    int errs    = 0;

    logic       loop_en;
    logic [7:0] slave_byte;
    int         base;
    int         nfall = 0;
    logic       slave_bit = 1'b0;

    relm_spi_master #(.WD(WD), .DIV(DIV)) dut (
        .clk          (clk),
        .rst_n_in     (rst_n_in),
        .cmd_in       (cmd_in),
        .retry_out    (retry_out),
        .ack_in       (ack_in),
        .q_out        (q_out),
        .spi_ss_out   (spi_ss_out),
        .spi_sck_out  (spi_sck_out),
        .spi_mosi_out (spi_mosi_out),
        .spi_miso_in  (spi_miso_in),
        .spi_int_in   (spi_int_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-3 slave: presents the next bit, MSB first, on each SCK fall.
    always @(negedge spi_sck_out) begin
        slave_bit = slave_byte[3'(7 - (nfall - base))];
        nfall     = nfall + 1;
    end

    assign spi_miso_in = loop_en ? spi_mosi_out : slave_bit;

    function automatic logic [WD:0] mk(input logic so, input logic ss,
                                       input logic [7:0] tx);
        mk      = '0;
        mk[WD]  = 1'b1;
        mk[9]   = so;
        mk[8]   = ss;
        mk[7:0] = tx;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command in cycle 0; returns in cycle 1.
    task automatic start(input logic [WD:0] c);
        cmd_in = c;
        tick();
        cmd_in = '0;
        ack_in = 1'b0;
    endtask

    // Runs cycles 1..16*DIV of a transfer; returns in cycle 16*DIV+1.
    task automatic xfer_body(input int inj, input logic [WD:0] icmd,
                             input logic ack_last, output logic [7:0] mo);
        int sck_bad;
        sck_bad = 0;
        mo      = 8'd0;
        for (int c = 1; c <= 16 * DIV; c++) begin
            if (spi_sck_out !== 1'(((c - 1) / DIV) % 2)) sck_bad++;
            if ((c - 1) % (2 * DIV) == DIV) mo = {mo[6:0], spi_mosi_out};
            if (c == inj) begin
                cmd_in = icmd;
                chk("retry_on_push", retry_out, 1);
            end
            if (c == 16 * DIV) begin
                ack_in = ack_last;
                chk("retry_last_cycle", retry_out, 1);
            end
            tick();
            cmd_in = '0;
            ack_in = 1'b0;
        end
        chk("sck_pattern", sck_bad, 0);
    endtask

    initial begin
        logic [7:0] mo;
        cmd_in     = '0;
        ack_in     = 1'b0;
        spi_int_in = 1'b0;
        loop_en    = 1'b1;
        slave_byte = 8'h00;
        base       = 0;
        rst_n_in   = 1'b1;
        #2 rst_n_in = 1'b0;
        #1;
        chk("rst_q", q_out, 0);
        chk("rst_ss", spi_ss_out, 1);
        chk("rst_sck", spi_sck_out, 1);
        chk("rst_mosi", spi_mosi_out, 0);
        chk("rst_retry", retry_out, 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();

        // Loopback 0xA5 with SS low.
        loop_en = 1'b1;
        start(mk(1'b0, 1'b0, 8'hA5));
        chk("a5_c1_ss", spi_ss_out, 0);
        chk("a5_c1_sck", spi_sck_out, 0);
        chk("a5_c1_mosi", spi_mosi_out, 1);
        chk("a5_c1_busy", retry_out, 1);
        xfer_body(-1, '0, 1'b0, mo);
        chk("a5_mosi_bits", mo, 8'hA5);
        chk("a5_rx", q_out[7:0], 8'hA5);
        chk("a5_fresh", q_out[WD-1], 1);
        chk("a5_ss", spi_ss_out, 0);
        chk("a5_idle", retry_out, 0);

        // Slave returns 0x3C while TX 0xFF; push with SS=1 at cycle 10.
        loop_en    = 1'b0;
        slave_byte = 8'h3C;
        base       = nfall;
        start(mk(1'b0, 1'b0, 8'hFF));
        xfer_body(10, mk(1'b0, 1'b1, 8'h55), 1'b0, mo);
        chk("ff_mosi_bits", mo, 8'hFF);
        chk("3c_q", q_out, {1'b0, 1'b1, 1'b0, 22'd0, 8'h3C});
        chk("3c_ss_kept", spi_ss_out, 0);
        chk("repush_retry", retry_out, 0);

        // Re-push at completion cycle together with ack.
        loop_en = 1'b1;
        ack_in  = 1'b1;
        start(mk(1'b0, 1'b0, 8'h55));
        chk("ack_fresh", q_out[WD-1], 0);
        chk("ack_rx_hold", q_out[7:0], 8'h3C);
        chk("repush_busy", retry_out, 1);
        xfer_body(-1, '0, 1'b1, mo);
        chk("ack_done_fresh", q_out[WD-1], 1);
        chk("55_rx", q_out[7:0], 8'h55);

        // Second completion without ack.
        start(mk(1'b0, 1'b0, 8'hC3));
        xfer_body(-1, '0, 1'b0, mo);
        chk("c3_rx", q_out[7:0], 8'hC3);
        chk("c3_fresh", q_out[WD-1], 1);

        // SS-only commands.
        cmd_in = mk(1'b1, 1'b1, 8'h00);
        chk("sso_c0_retry", retry_out, 0);
        tick();
        cmd_in = '0;
        chk("sso_hi_ss", spi_ss_out, 1);
        chk("sso_hi_retry", retry_out, 0);
        chk("sso_hi_sck", spi_sck_out, 1);
        tick();
        chk("sso_hi_retry2", retry_out, 0);
        start(mk(1'b1, 1'b0, 8'hFF));
        chk("sso_lo_ss", spi_ss_out, 0);
        chk("sso_lo_retry", retry_out, 0);
        tick();

        // Reset in cycle 30 of a transfer.
        start(mk(1'b0, 1'b0, 8'h96));
        for (int i = 0; i < 29; i++) tick();
        chk("pre_rst_mosi", spi_mosi_out, 1);
        chk("pre_rst_ss", spi_ss_out, 0);
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_ss", spi_ss_out, 1);
        chk("mid_rst_sck", spi_sck_out, 1);
        chk("mid_rst_mosi", spi_mosi_out, 0);
        chk("mid_rst_fresh", q_out[WD-1], 0);
        chk("mid_rst_retry", retry_out, 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        chk("post_rst_fresh", q_out[WD-1], 0);
        start(mk(1'b0, 1'b0, 8'h5A));
        xfer_body(-1, '0, 1'b0, mo);
        chk("5a_rx", q_out[7:0], 8'h5A);
        chk("5a_fresh", q_out[WD-1], 1);

        // Interrupt synchronizer latency.
        spi_int_in = 1'b1;
        chk("int_c0", q_out[WD-2], 0);
        tick();
        chk("int_c1", q_out[WD-2], 0);
        spi_int_in = 1'b0;
        tick();
        chk("int_c2", q_out[WD-2], 1);
        tick();
        chk("int_c3", q_out[WD-2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
